// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the byte-serial RAM arbiter: sizes, FSM states, owners,
// and the packed grant record handed from arbitration to the byte sequencer.
package mem_arbiter_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_MEM = 1'b1;

    typedef struct packed {
        logic        owner;
        logic        we;
        logic [2:0]  n;
        logic [31:0] base;
        logic [31:0] wdata;
    } grant_t;

    // Size code 3 is deliberately treated as a word access.
    function automatic logic [2:0] size_to_n(input logic [1:0] size);
        case (size)
            SIZE_B:  return 3'd1;
            SIZE_H:  return 3'd2;
            SIZE_W:  return 3'd4;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_byte_seq.sv
// Byte sequencer: issues n byte accesses from base (address wraps mod 2^32), one per cycle after start;
// loads capture each byte one cycle after its address. No backpressure: RAM accepts one byte per cycle.
module mem_byte_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] base,
    input  logic [2:0]  n,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] ram_addr_o,
    output logic        ram_we_o,
    output logic [7:0]  ram_wdata_o,
    input  logic [7:0]  ram_rdata_i,
    output logic [31:0] result_o,
    output logic        last_o
);
    logic        issue_q;
    logic        we_q;
    logic [2:0]  n_q;
    logic [1:0]  idx_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        cap_vld_q;
    logic [1:0]  cap_idx_q;
    logic [31:0] res_q;
    logic        issue_last;
    logic        cap_last;

    assign issue_last  = ({1'b0, idx_q} == (n_q - 3'd1));
    assign cap_last    = ({1'b0, cap_idx_q} == (n_q - 3'd1));
    assign ram_addr_o  = addr_q;
    assign ram_we_o    = issue_q & we_q;
    assign ram_wdata_o = wdata_q[7:0];
    assign last_o      = (issue_q & we_q & issue_last) | (cap_vld_q & cap_last);

    // Result with the byte arriving this cycle already merged in, so the
    // owner's output register can take the complete word on the final edge.
    assign result_o = cap_vld_q ? (res_q | (32'(ram_rdata_i) << {cap_idx_q, 3'b000})) : res_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_q   <= 1'b0;
            we_q      <= 1'b0;
            n_q       <= 3'd0;
            idx_q     <= 2'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            cap_vld_q <= 1'b0;
            cap_idx_q <= 2'd0;
            res_q     <= 32'd0;
        end else begin
            cap_vld_q <= issue_q & ~we_q;
            cap_idx_q <= idx_q;
            if (cap_vld_q) begin
                res_q <= result_o;
            end
            if (start) begin
                issue_q <= 1'b1;
                we_q    <= we;
                n_q     <= n;
                idx_q   <= 2'd0;
                addr_q  <= base;
                wdata_q <= wdata;
                res_q   <= 32'd0;
            end else if (issue_q) begin
                if (issue_last) begin
                    issue_q <= 1'b0;
                end else begin
                    idx_q   <= idx_q + 2'd1;
                    addr_q  <= addr_q + 32'd1;
                    wdata_q <= wdata_q >> 8;
                end
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// IF/MEM arbiter for a byte-wide RAM; store done at n+1, load/fetch done at n+2 cycles after request.
// Losing requester waits in IDLE; round-robin when MEM_ARB_RR_EN is defined, else MEM has priority.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_done_o,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [1:0]  mem_size_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_done_o,
    output logic [31:0] ram_addr_o,
    output logic        ram_we_o,
    output logic [7:0]  ram_wdata_o,
    input  logic [7:0]  ram_rdata_i,
    output logic        busy_o
);
    import mem_arbiter_pkg::*;

    logic [1:0]  state_q;
    logic        owner_q;
    logic        we_q;
    logic        pick_mem;
    logic        start;
    logic        seq_last;
    logic [31:0] seq_result;
    grant_t      grant;

    assign start  = (state_q == ST_IDLE) & (if_req_i | mem_req_i);
    assign busy_o = (state_q != ST_IDLE);

`ifdef MEM_ARB_RR_EN
    // Reset value says IF was served last, so MEM wins the first contest.
    logic last_if_q;

    assign pick_mem = mem_req_i & (~if_req_i | last_if_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_if_q <= 1'b1;
        end else if (start) begin
            last_if_q <= ~pick_mem;
        end
    end
`else
    assign pick_mem = mem_req_i;
`endif

    always_comb begin
        grant = '0;
        if (pick_mem) begin
            grant.owner = OWN_MEM;
            grant.we    = mem_we_i;
            grant.n     = size_to_n(mem_size_i);
            grant.base  = mem_addr_i;
            grant.wdata = mem_wdata_i;
        end else begin
            grant.owner = OWN_IF;
            grant.we    = 1'b0;
            grant.n     = 3'd4;
            grant.base  = if_addr_i;
        end
    end

    mem_byte_seq u_seq (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base        (grant.base),
        .n           (grant.n),
        .we          (grant.we),
        .wdata       (grant.wdata),
        .ram_addr_o  (ram_addr_o),
        .ram_we_o    (ram_we_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_rdata_i (ram_rdata_i),
        .result_o    (seq_result),
        .last_o      (seq_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            we_q        <= 1'b0;
            if_data_o   <= 32'd0;
            mem_rdata_o <= 32'd0;
            if_done_o   <= 1'b0;
            mem_done_o  <= 1'b0;
        end else begin
            if_done_o  <= 1'b0;
            mem_done_o <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_XFER;
                        owner_q <= grant.owner;
                        we_q    <= grant.we;
                    end
                end
                ST_XFER: begin
                    // Done and data are registered here so both appear in the DONE cycle.
                    if (seq_last) begin
                        state_q <= ST_DONE;
                        if (owner_q == OWN_IF) begin
                            if_done_o <= 1'b1;
                            if_data_o <= seq_result;
                        end else begin
                            mem_done_o <= 1'b1;
                            if (!we_q) begin
                                mem_rdata_o <= seq_result;
                            end
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed table, arbitration and reset sequences, then random
// transactions checked against a byte-array memory model.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic [31:0] if_data;
    logic        if_done;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [1:0]  mem_size = 2'd0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic [31:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = 8'd0;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    bit [7:0]    ram [bit [31:0]];
    bit [7:0]    model_mem [bit [31:0]];
    logic [31:0] addr_hist [int];
    logic        we_hist [int];
    logic [7:0]  wd_hist [int];
    logic        busy_hist [int];
    logic [31:0] exp_if_data = 32'd0;
    logic [31:0] exp_mem_rdata = 32'd0;

    typedef struct {
        bit          is_mem;
        bit          we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    mem_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_data_o   (if_data),
        .if_done_o   (if_done),
        .mem_req_i   (mem_req),
        .mem_we_i    (mem_we),
        .mem_size_i  (mem_size),
        .mem_addr_i  (mem_addr),
        .mem_wdata_i (mem_wdata),
        .mem_rdata_o (mem_rdata),
        .mem_done_o  (mem_done),
        .ram_addr_o  (ram_addr),
        .ram_we_o    (ram_we),
        .ram_wdata_o (ram_wdata),
        .ram_rdata_i (ram_rdata),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    function automatic bit [7:0] ram_byte(input bit [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    function automatic bit [7:0] model_byte(input bit [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : 8'h00;
    endfunction

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input int n);
        logic [31:0] r;
        r = 32'd0;
        for (int i = 0; i < n; i++) r[8*i +: 8] = model_byte(a + 32'(i));
        return r;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        ram_rdata <= ram_byte(ram_addr);
    end

    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] = ram_wdata;
    end

    always @(negedge clk) begin
        addr_hist[cyc] = ram_addr;
        we_hist[cyc]   = ram_we;
        wd_hist[cyc]   = ram_wdata;
        busy_hist[cyc] = busy;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [7:0] b);
        ram[a] = b;
        model_mem[a] = b;
    endtask

    task automatic do_txn(input bit is_mem, input bit we, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output logic [31:0] data);
        int n, c0, exp_lat;
        bit got, wrong, bus_ok;
        if (!is_mem) we = 1'b0;
        n = is_mem ? nbytes(size) : 4;
        exp_lat = we ? n + 1 : n + 2;
        @(posedge clk); #1;
        c0 = cyc;
        if (is_mem) begin
            mem_we = we; mem_size = size; mem_addr = addr; mem_wdata = wdata; mem_req = 1'b1;
        end else begin
            if_addr = addr; if_req = 1'b1;
        end
        got = 1'b0; wrong = 1'b0; lat = -1;
        for (int k = 0; k < 30 && !got; k++) begin
            @(negedge clk);
            if (is_mem ? if_done : mem_done) wrong = 1'b1;
            if (is_mem ? mem_done : if_done) begin
                got = 1'b1;
                lat = cyc - c0;
            end
        end
        @(posedge clk); #1;
        mem_req = 1'b0;
        if_req = 1'b0;

        if (we) begin
            for (int i = 0; i < n; i++) model_mem[addr + 32'(i)] = wdata[8*i +: 8];
        end else if (is_mem) begin
            exp_mem_rdata = model_load(addr, n);
        end else begin
            exp_if_data = model_load(addr, 4);
        end

        check("done_seen", 32'(got), 32'd1);
        check("latency", lat, exp_lat);
        check("other_done", 32'(wrong), 32'd0);
        check("if_data", if_data, exp_if_data);
        check("mem_rdata", mem_rdata, exp_mem_rdata);

        bus_ok = 1'b1;
        if (busy_hist[c0] !== 1'b0) bus_ok = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (addr_hist[c0+1+i] !== addr + 32'(i)) bus_ok = 1'b0;
            if (we_hist[c0+1+i] !== we) bus_ok = 1'b0;
            if (we && wd_hist[c0+1+i] !== wdata[8*i +: 8]) bus_ok = 1'b0;
            if (busy_hist[c0+1+i] !== 1'b1) bus_ok = 1'b0;
        end
        if (we_hist[c0+n+1] !== 1'b0) bus_ok = 1'b0;
        check("bus_seq", 32'(bus_ok), 32'd1);
        data = is_mem ? mem_rdata : if_data;
    endtask

    initial begin
        vec_t        vecs [10];
        int          lat, c0;
        logic [31:0] data;
        string       order, exp_order;
        bit          saw_if, saw;

        vecs[0] = '{1'b0, 1'b0, 2'd2, 32'h0000_0100, 32'h0,         32'h0010_0513, 6};
        vecs[1] = '{1'b1, 1'b1, 2'd2, 32'h0000_0200, 32'hDEAD_BEEF, 32'h0,         5};
        vecs[2] = '{1'b1, 1'b0, 2'd1, 32'h0000_03FF, 32'h0,         32'h0000_FF80, 4};
        vecs[3] = '{1'b1, 1'b1, 2'd0, 32'hFFFF_FFFF, 32'h0000_00AB, 32'h0,         2};
        vecs[4] = '{1'b0, 1'b0, 2'd2, 32'hFFFF_FFFE, 32'h0,         32'h3322_AB11, 6};
        vecs[5] = '{1'b1, 1'b0, 2'd2, 32'h0000_0200, 32'h0,         32'hDEAD_BEEF, 6};
        vecs[6] = '{1'b1, 1'b0, 2'd0, 32'h0000_03FF, 32'h0,         32'h0000_0080, 3};
        vecs[7] = '{1'b1, 1'b0, 2'd3, 32'h0000_0200, 32'h0,         32'hDEAD_BEEF, 6};
        vecs[8] = '{1'b1, 1'b1, 2'd1, 32'h0000_0201, 32'h1234_5678, 32'h0,         3};
        vecs[9] = '{1'b1, 1'b0, 2'd2, 32'h0000_0200, 32'h0,         32'hDE56_78EF, 6};

        preload(32'h100, 8'h13); preload(32'h101, 8'h05);
        preload(32'h102, 8'h10); preload(32'h103, 8'h00);
        preload(32'h3FF, 8'h80); preload(32'h400, 8'hFF);
        preload(32'hFFFF_FFFE, 8'h11);
        preload(32'h0, 8'h22);   preload(32'h1, 8'h33);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_data", {if_data[15:0], mem_rdata[15:0]} | if_data | mem_rdata | ram_addr, 32'd0);
        check("reset_ctl", {27'd0, if_done, mem_done, ram_we, busy, |ram_wdata}, 32'd0);

        // Both requesters stay active for three grants, re-requesting after each done.
        @(posedge clk); #1;
        if_addr = 32'h100; if_req = 1'b1;
        mem_we = 1'b0; mem_size = 2'd0; mem_addr = 32'h3FF; mem_req = 1'b1;
        order = ""; saw_if = 1'b0;
        for (int k = 0; k < 60 && order.len() < 3; k++) begin
            @(negedge clk);
            if (if_done) begin order = {order, "I"}; saw_if = 1'b1; end
            if (mem_done) order = {order, "M"};
        end
        @(posedge clk); #1;
        if_req = 1'b0; mem_req = 1'b0;
`ifdef MEM_ARB_RR_EN
        exp_order = "MIM";
`else
        exp_order = "MMM";
`endif
        checks++;
        if (order != exp_order) begin
            failures++;
            $display("FAIL arb_order got=%s expected=%s", order, exp_order);
        end
        exp_mem_rdata = model_load(32'h3FF, 1);
        if (saw_if) exp_if_data = model_load(32'h100, 4);
        repeat (2) @(posedge clk);
        check("arb_if_data", if_data, exp_if_data);
        check("arb_mem_rdata", mem_rdata, exp_mem_rdata);

        for (int i = 0; i < 10; i++) begin
            do_txn(vecs[i].is_mem, vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata, lat, data);
            check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
            if (!vecs[i].we) check($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
        end

        for (int i = 0; i < 40; i++) begin
            logic [31:0] base;
            case ($urandom_range(0, 3))
                0: base = 32'h0000_0200;
                1: base = 32'h0000_03FC;
                2: base = 32'hFFFF_FFFC;
                default: base = 32'h0000_1000;
            endcase
            do_txn($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   base + 32'($urandom_range(0, 7)), $urandom, lat, data);
        end

        // Reset in cycle 2 of a word store: two bytes land, then the bus goes quiet.
        @(posedge clk); #1;
        c0 = cyc;
        mem_we = 1'b1; mem_size = 2'd2; mem_addr = 32'h500; mem_wdata = 32'hCAFE_F00D; mem_req = 1'b1;
        saw = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (k == 2) begin rst = 1'b1; mem_req = 1'b0; end
            if (k == 4) rst = 1'b0;
            @(negedge clk);
            if (mem_done || if_done) saw = 1'b1;
            @(posedge clk); #1;
        end
        check("rst_we_c2", 32'(we_hist[c0+2]), 32'd1);
        check("rst_we_c3", 32'(we_hist[c0+3]), 32'd0);
        check("rst_no_done", 32'(saw), 32'd0);
        check("rst_outputs", if_data | mem_rdata | 32'(busy), 32'd0);
        model_mem[32'h500] = 8'h0D;
        model_mem[32'h501] = 8'hF0;
        exp_if_data = 32'd0;
        exp_mem_rdata = 32'd0;
        do_txn(1'b1, 1'b0, 2'd2, 32'h500, 32'h0, lat, data);
        check("rst_partial", data, 32'h0000_F00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
